ultra_sonic_scheduler: RTL and testbench

Round-robin sequencer that time-shares one ranging engine across up to N HC-SR04-style ultrasonic sensors on the car. It fires each enabled sensor's trigger in turn, times that sensor's echo pulse with a timeout, converts the pulse width to centimetres with an incremental divider (no hardware `/`), and publishes a per-channel distance table plus near-obstacle flags to the drive/ESP8266 command logic. Only one sensor is in flight at a time, which prevents acoustic crosstalk between them.

---
 rtl/ultra_sonic_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_ultra_sonic_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultra_sonic_scheduler.sv
// Round-robin scheduler sharing one echo-timing engine across N ultrasonic sensors.
// One sensor is in flight at a time; results land in a per-channel distance table.

module ultra_sonic_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module ultra_sonic_scheduler #(
   parameter int N_SENSORS      = 4,
   parameter int TRIG_CYCLES    = 550,
   parameter int CYCLES_PER_CM  = 2900,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int GUARD_CYCLES   = 500_000,
   parameter int DIST_W         = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [N_SENSORS-1:0]        ch_mask,
   input  logic [DIST_W-1:0]           near_thresh_cm,
   input  logic [N_SENSORS-1:0]        echo,
   output logic [N_SENSORS-1:0]        trigger,
   output logic [N_SENSORS*DIST_W-1:0] dist_cm,
   output logic [N_SENSORS-1:0]        near,
   output logic [N_SENSORS-1:0]        valid,
   output logic [N_SENSORS-1:0]        timeout,
   output logic                        sample_valid,
   output logic [2:0]                  sample_ch
);
   localparam int CH_W  = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
   localparam int TMAX0 = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
   localparam int TMAX  = (TMAX0 > TRIG_CYCLES) ? TMAX0 : TRIG_CYCLES;
   localparam int TMR_W = $clog2(TMAX + 1);
   localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);

   localparam logic [DIST_W-1:0] DIST_MAX  = '1;
   localparam logic [DIST_W-1:0] CM_SAT    = DIST_MAX - 1'b1;
   localparam logic [TMR_W-1:0]  TRIG_END  = TMR_W'(TRIG_CYCLES);
   localparam logic [TMR_W-1:0]  WAIT_END  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  MEAS_END  = TMR_W'(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0]  GUARD_END = TMR_W'(GUARD_CYCLES - 1);
   localparam logic [SUB_W-1:0]  SUB_END   = SUB_W'(CYCLES_PER_CM - 1);
   // The rise cycle is already one echo-high cycle, so counting starts at 1.
   localparam logic [SUB_W-1:0]  SUB_INIT  = (CYCLES_PER_CM == 1) ? '0 : SUB_W'(1);
   localparam logic [DIST_W-1:0] CM_INIT   = (CYCLES_PER_CM == 1) ? DIST_W'(1) : '0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_TRIG   = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_MEAS   = 3'd3;
   localparam logic [2:0] S_RESULT = 3'd4;
   localparam logic [2:0] S_GUARD  = 3'd5;

   logic [2:0]           state;
   logic [CH_W-1:0]      ch;
   logic [TMR_W-1:0]     tmr, tmr_inc;
   logic [SUB_W-1:0]     sub;
   logic [DIST_W-1:0]    cm_acc;
   logic [N_SENSORS-1:0] echo_s;
   logic                 echo_cur, echo_prev, rise;
   logic                 res_go, res_to;

   genvar g;
   generate
      for (g = 0; g < N_SENSORS; g++) begin : g_lane
         ultra_sonic_sync u_sync (.clk(clk), .rst(rst), .d(echo[g]), .q(echo_s[g]));
         assign near[g] = valid[g] & ~timeout[g] &
                          (dist_cm[g*DIST_W +: DIST_W] < near_thresh_cm);
      end
   endgenerate

   assign echo_cur = echo_s[ch];
   assign rise     = echo_cur & ~echo_prev;
   assign tmr_inc  = tmr + 1'b1;

   // Lowest set mask bit at or after (start + off), wrapping; start if none set.
   function automatic logic [CH_W-1:0] pick(input logic [CH_W-1:0] start,
                                           input logic [N_SENSORS-1:0] m, input int off);
      logic [CH_W-1:0] r;
      logic            hit;
      int              idx;
      r   = start;
      hit = 1'b0;
      for (int i = 0; i < N_SENSORS; i++) begin
         idx = (int'(start) + off + i) % N_SENSORS;
         if (!hit && m[idx]) begin
            r   = CH_W'(idx);
            hit = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      res_go = 1'b0;
      res_to = 1'b0;
      if (state == S_WAIT && !rise && tmr == WAIT_END) begin
         res_go = 1'b1;
         res_to = 1'b1;
      end
      if (state == S_MEAS) begin
         if (!echo_cur) begin
            res_go = 1'b1;
         end else if (tmr_inc == MEAS_END) begin
            res_go = 1'b1;
            res_to = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IDLE;
         ch           <= '0;
         tmr          <= '0;
         sub          <= '0;
         cm_acc       <= '0;
         echo_prev    <= 1'b0;
         trigger      <= '0;
         dist_cm      <= '1;
         valid        <= '0;
         timeout      <= '0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
      end else begin
         echo_prev    <= echo_cur;
         sample_valid <= 1'b0;
         case (state)
            S_IDLE: if (enable && |ch_mask) begin
               ch    <= pick(ch, ch_mask, 0);
               tmr   <= '0;
               state <= S_TRIG;
            end
            S_TRIG: if (tmr == TRIG_END) begin
               trigger <= '0;
               tmr     <= '0;
               state   <= S_WAIT;
            end else begin
               trigger <= N_SENSORS'(1) << ch;
               tmr     <= tmr_inc;
            end
            S_WAIT: if (rise) begin
               sub    <= SUB_INIT;
               cm_acc <= CM_INIT;
               tmr    <= TMR_W'(1);
               state  <= S_MEAS;
            end else if (res_go) begin
               state <= S_RESULT;
            end else begin
               tmr <= tmr_inc;
            end
            S_MEAS: if (res_go) begin
               state <= S_RESULT;
            end else begin
               sub <= (sub == SUB_END) ? '0 : sub + 1'b1;
               if (sub == SUB_END && cm_acc != CM_SAT) cm_acc <= cm_acc + 1'b1;
               tmr <= tmr_inc;
            end
            S_RESULT: begin
               tmr   <= '0;
               state <= S_GUARD;
            end
            S_GUARD: if (tmr == GUARD_END) begin
               ch    <= pick(ch, ch_mask, 1);
               tmr   <= '0;
               state <= (enable && |ch_mask) ? S_TRIG : S_IDLE;
            end else begin
               tmr <= tmr_inc;
            end
            default: state <= S_IDLE;
         endcase
         // Table write happens on the edge entering RESULT.
         if (res_go) begin
            dist_cm[ch*DIST_W +: DIST_W] <= res_to ? DIST_MAX : cm_acc;
            valid[ch]    <= 1'b1;
            timeout[ch]  <= res_to;
            sample_valid <= 1'b1;
            sample_ch    <= 3'(ch);
         end
      end
   end
endmodule

// File: tb/tb_ultra_sonic_scheduler.sv
// Directed bench for ultra_sonic_scheduler: 2 channels with short timings.

module tb_ultra_sonic_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  ch_mask = 2'b00;
   logic [9:0]  near_thresh_cm = 10'd0;
   logic [1:0]  echo = 2'b00;
   logic [1:0]  trigger, near, valid, timeout;
   logic [19:0] dist_cm;
   logic        sample_valid;
   logic [2:0]  sample_ch;

   int vectors = 0;
   int miscompares = 0;

   ultra_sonic_scheduler #(
      .N_SENSORS(2), .TRIG_CYCLES(4), .CYCLES_PER_CM(10),
      .TIMEOUT_CYCLES(1000), .GUARD_CYCLES(20), .DIST_W(10)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
      .near_thresh_cm(near_thresh_cm), .echo(echo), .trigger(trigger),
      .dist_cm(dist_cm), .near(near), .valid(valid), .timeout(timeout),
      .sample_valid(sample_valid), .sample_ch(sample_ch)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Waits for channel c's trigger, plays an echo of width wid starting dly cycles
   // after the trigger falls, and reports what the DUT published.
   // obs = {got, sv_long, bad_trig, trig_cycles[3:0], sample_ch, timeout, valid, dist}
   task automatic ping(input int c, input int dly, input int wid, input bit drop_en,
                       output logic [21:0] obs);
      logic       got, sv_long, bad, to_b, vld_b;
      logic [2:0] sch;
      logic [9:0] d;
      logic [1:0] mine;
      int         tcnt;
      got = 0; sv_long = 0; bad = 0; to_b = 0; vld_b = 0; sch = 0; d = 0; tcnt = 0;
      mine = 2'b01 << c;
      for (int k = 0; k < 3000 && trigger !== mine; k++) begin
         @(negedge clk);
         if (trigger !== 2'b00 && trigger !== mine) bad = 1;
      end
      if (trigger === mine) begin
         if (drop_en) enable = 1'b0;
         while (trigger === mine && tcnt < 50) begin
            tcnt++;
            @(negedge clk);
         end
         if (trigger !== 2'b00) bad = 1;
         for (int k = 0; k < 3000; k++) begin
            if (sample_valid === 1'b1 && !got) begin
               got = 1; sch = sample_ch; to_b = timeout[c]; vld_b = valid[c];
               d = dist_cm[c*10 +: 10];
            end
            if (got && k >= dly + wid) break;
            echo[c] = (k >= dly) && (k < dly + wid);
            @(negedge clk);
            if (trigger !== 2'b00) bad = 1;
         end
         echo[c] = 1'b0;
         @(negedge clk);
         if (sample_valid !== 1'b0) sv_long = 1;
      end
      obs = {got, sv_long, bad, 4'(tcnt), sch, to_b, vld_b, d};
   endtask

   task automatic test_reset;
      logic [31:0] exp, got;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      got = {trigger, dist_cm, valid, timeout, near, sample_valid, sample_ch};
      exp = {2'b00, 20'hFFFFF, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", got, exp);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [21:0] obs, exp;
      bit stray;
      ch_mask = 2'b01; near_thresh_cm = 10'd30; enable = 1'b1;
      ping(0, 30, 253, 1, obs);
      exp = {1'b1, 1'b0, 1'b0, 4'd4, 3'd0, 1'b0, 1'b1, 10'd25};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL basic_ping: got %h want %h", obs, exp);
      end
      vectors++;
      if (near !== 2'b01) begin
         miscompares++;
         $display("FAIL near_thresh30: got %b want 01", near);
      end
      near_thresh_cm = 10'd25;
      #1;
      vectors++;
      if (near !== 2'b00) begin
         miscompares++;
         $display("FAIL near_thresh25: got %b want 00", near);
      end
      stray = 0;
      repeat (80) begin
         @(negedge clk);
         if (trigger !== 2'b00) stray = 1;
      end
      vectors++;
      if (stray) begin
         miscompares++;
         $display("FAIL enable_drop_idle: got stray trigger want none");
      end
   endtask

   task automatic test_round_robin;
      logic [21:0] obs, exp;
      ch_mask = 2'b11; enable = 1'b1;
      ping(0, 10, 100, 0, obs);
      exp = {1'b1, 1'b0, 1'b0, 4'd4, 3'd0, 1'b0, 1'b1, 10'd10};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL rr_ch0_first: got %h want %h", obs, exp);
      end
      ping(1, 10, 57, 0, obs);
      exp = {1'b1, 1'b0, 1'b0, 4'd4, 3'd1, 1'b0, 1'b1, 10'd5};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL rr_ch1: got %h want %h", obs, exp);
      end
      ping(0, 5, 100, 1, obs);
      exp = {1'b1, 1'b0, 1'b0, 4'd4, 3'd0, 1'b0, 1'b1, 10'd10};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL rr_ch0_again: got %h want %h", obs, exp);
      end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_no_echo;
      logic [21:0] obs, exp;
      ch_mask = 2'b10; enable = 1'b1;
      ping(1, 0, 0, 0, obs);
      exp = {1'b1, 1'b0, 1'b0, 4'd4, 3'd1, 1'b1, 1'b1, 10'd1023};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL no_echo_timeout: got %h want %h", obs, exp);
      end
      ping(1, 20, 40, 1, obs);
      exp = {1'b1, 1'b0, 1'b0, 4'd4, 3'd1, 1'b0, 1'b1, 10'd4};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL echo_after_timeout: got %h want %h", obs, exp);
      end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_stuck_echo;
      logic [21:0] obs, exp;
      ch_mask = 2'b01; near_thresh_cm = 10'd1023; enable = 1'b1;
      ping(0, 10, 1200, 1, obs);
      exp = {1'b1, 1'b0, 1'b0, 4'd4, 3'd0, 1'b1, 1'b1, 10'd1023};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL stuck_echo: got %h want %h", obs, exp);
      end
      vectors++;
      if (near !== 2'b10) begin
         miscompares++;
         $display("FAIL near_timeout: got %b want 10", near);
      end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [31:0] exp, got;
      ch_mask = 2'b01; enable = 1'b1;
      for (int k = 0; k < 500 && trigger !== 2'b01; k++) @(negedge clk);
      for (int k = 0; k < 50 && trigger !== 2'b00; k++) @(negedge clk);
      repeat (10) @(negedge clk);
      echo[0] = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      got = {trigger, dist_cm, valid, timeout, near, sample_valid, sample_ch};
      exp = {2'b00, 20'hFFFFF, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_mid_measure: got %h want %h", got, exp);
      end
      echo[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 500 && trigger !== 2'b01; k++) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (trigger !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_mid_trig: got %b want 00", trigger);
      end
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_no_echo();
      test_stuck_echo();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
